ppu_vbuf_wr: RTL and testbench

PPU_VBUF_WR -- requirements
Module: ppu_vbuf_wr

---
 rtl/ppu_vbuf_pkg.sv | 32 +++
 rtl/ppu_vbuf_wr_fifo.sv | 62 ++++++
 rtl/ppu_vbuf_wr.sv | 139 +++++++++++++
 tb/tb_ppu_vbuf_wr.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_vbuf_pkg.sv
// Shared definitions for the PPU video-buffer write path: frame geometry,
// address width, writer FSM states and the queued write-entry layout.
package ppu_vbuf_pkg;

  localparam int FRAME_W = 256;
  localparam int FRAME_H = 240;
  localparam int VBUF_AW = 17;

  // Coordinates of the final pixel of a frame.
  localparam logic [7:0] LAST_X = 8'(FRAME_W - 1);
  localparam logic [7:0] LAST_Y = 8'(FRAME_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // One queued write: target page, coordinates and colour code (25 bits).
  typedef struct packed {
    logic       page;
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] hsv;
  } vbuf_entry_t;

  // Video-buffer address of an entry: {page, y, x}.
  function automatic logic [VBUF_AW-1:0] entry_addr(input vbuf_entry_t e);
    return {e.page, e.y, e.x};
  endfunction

endpackage

// File: rtl/ppu_vbuf_wr_fifo.sv
// Synchronous write FIFO for the video-buffer writer. Registered occupancy
// count, head available combinationally from storage. DEPTH must be a power
// of two (>= 2) so the pointers wrap naturally.
module ppu_vbuf_wr_fifo
  import ppu_vbuf_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        i_lcd_clk,
  input  logic        i_lcd_rstn,
  input  logic        push,
  input  vbuf_entry_t push_data,
  input  logic        pop,
  output vbuf_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  vbuf_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only legal when the head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (PW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_lcd_clk or negedge i_lcd_rstn) begin
    if (!i_lcd_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately not reset; emptiness is tracked by count,
  // so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge i_lcd_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ppu_vbuf_wr.sv
// PPU video-buffer writer. Tags each pixel of the unstallable PPU stream
// with its (x, y) position and the page being drawn, queues it, and presents
// the queue head as a write request to the video buffer.
// Optional feature: define PPU_VBUF_WR_DROP_CNT_EN to build the saturating
// dropped-pixel counter on o_drop_cnt; otherwise o_drop_cnt is tied to 0.
module ppu_vbuf_wr
  import ppu_vbuf_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic               i_lcd_clk,
  input  logic               i_lcd_rstn,
  input  logic               i_pix_vld,
  input  logic               i_pix_sof,
  input  logic [7:0]         i_pix_hsv,
  input  logic               i_rd_page,
  output logic               o_vbuf_we,
  output logic [VBUF_AW-1:0] o_vbuf_waddr,
  output logic [7:0]         o_vbuf_wdata,
  input  logic               i_vbuf_gnt,
  output logic               o_wr_page,
  output logic               o_frame_done,
  output logic               o_err_short,
  output logic               o_err_ovf,
  output logic [15:0]        o_drop_cnt
);

  state_t      state;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        start;
  logic        take;
  logic        is_last;
  logic        pop;
  logic        push;
  logic        drop;
  logic        fifo_full;
  logic        fifo_empty;
  vbuf_entry_t push_entry;
  vbuf_entry_t head;

  // A sof pixel restarts the frame from any state; other pixels only count
  // while a frame is active, and are silently ignored otherwise.
  assign start   = i_pix_vld && i_pix_sof;
  assign take    = i_pix_vld && (i_pix_sof || (state == ST_ACTIVE));
  assign is_last = take && (push_entry.x == LAST_X) && (push_entry.y == LAST_Y);

  assign pop  = o_vbuf_we && i_vbuf_gnt;
  assign push = take && (!fifo_full || pop);
  assign drop = take && !push;

  // Build the entry for the incoming pixel; a sof pixel is (0,0) on the new page.
  // NOTE: every field gets a default first so no path leaves a latch behind.
  always_comb begin
    push_entry      = '0;
    push_entry.hsv  = i_pix_hsv;
    push_entry.page = o_wr_page;
    push_entry.x    = x;
    push_entry.y    = y;
    if (i_pix_sof) begin
      push_entry.page = ~i_rd_page;
      push_entry.x    = '0;
      push_entry.y    = '0;
    end
  end

  ppu_vbuf_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_lcd_clk (i_lcd_clk),
    .i_lcd_rstn(i_lcd_rstn),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_vbuf_we    = !fifo_empty;
  assign o_vbuf_waddr = entry_addr(head);
  assign o_vbuf_wdata = head.hsv;

  // Frame FSM: position counters, page selection, done pulse and sticky errors.
  always_ff @(posedge i_lcd_clk or negedge i_lcd_rstn) begin
    if (!i_lcd_rstn) begin
      state        <= ST_IDLE;
      x            <= '0;
      y            <= '0;
      o_wr_page    <= 1'b0;
      o_frame_done <= 1'b0;
      o_err_short  <= 1'b0;
      o_err_ovf    <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (take) begin
        // Coordinates advance whether the pixel was queued or dropped.
        if (is_last) begin
          state        <= ST_DONE;
          x            <= '0;
          y            <= '0;
          o_frame_done <= 1'b1;
        end else begin
          state <= ST_ACTIVE;
          if (push_entry.x == LAST_X) begin
            x <= '0;
            y <= push_entry.y + 8'd1;
          end else begin
            x <= push_entry.x + 8'd1;
            y <= push_entry.y;
          end
        end
      end
      if (start) o_wr_page <= ~i_rd_page;
      if (start && (state == ST_ACTIVE)) o_err_short <= 1'b1;
      if (drop) o_err_ovf <= 1'b1;
    end
  end

`ifdef PPU_VBUF_WR_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating dropped-pixel counter, restarted by each sof pixel.
  always_ff @(posedge i_lcd_clk or negedge i_lcd_rstn) begin
    if (!i_lcd_rstn) begin
      drop_cnt <= '0;
    end else if (start) begin
      drop_cnt <= {15'd0, drop};
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign o_drop_cnt = drop_cnt;
`else
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ppu_vbuf_wr.sv
// Self-checking bench for ppu_vbuf_wr: a vector table for single-cycle
// behaviour plus directed sequences for frame, overflow, short-frame,
// full-with-pop and reset corner cases.
module tb_ppu_vbuf_wr;

`ifdef PPU_VBUF_WR_DROP_CNT_EN
  localparam int EXP_DROP = 2;
`else
  localparam int EXP_DROP = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        vld;
  logic        sof;
  logic [7:0]  hsv;
  logic        rd_page;
  logic        gnt;
  logic        we;
  logic [16:0] waddr;
  logic [7:0]  wdata;
  logic        wr_page;
  logic        frame_done;
  logic        err_short;
  logic        err_ovf;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppu_vbuf_wr #(
    .FIFO_DEPTH(8)
  ) dut (
    .i_lcd_clk   (clk),
    .i_lcd_rstn  (rstn),
    .i_pix_vld   (vld),
    .i_pix_sof   (sof),
    .i_pix_hsv   (hsv),
    .i_rd_page   (rd_page),
    .o_vbuf_we   (we),
    .o_vbuf_waddr(waddr),
    .o_vbuf_wdata(wdata),
    .i_vbuf_gnt  (gnt),
    .o_wr_page   (wr_page),
    .o_frame_done(frame_done),
    .o_err_short (err_short),
    .o_err_ovf   (err_ovf),
    .o_drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic        vld;
    logic        sof;
    logic [7:0]  hsv;
    logic        rd_page;
    logic        gnt;
    logic        exp_we;
    logic [16:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_page;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    vld     = 1'b0;
    sof     = 1'b0;
    hsv     = 8'h00;
    gnt     = 1'b0;
    rd_page = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic pixel(input logic s, input logic [7:0] h);
    vld = 1'b1;
    sof = s;
    hsv = h;
    next_cycle();
    vld = 1'b0;
    sof = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(we),         32'd0);
    check({tag, "_page"},  32'(wr_page),    32'd0);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
    check({tag, "_short"}, 32'(err_short),  32'd0);
    check({tag, "_ovf"},   32'(err_ovf),    32'd0);
    check({tag, "_drop"},  32'(drop_cnt),   32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  int          wr_idx;
  int          fd_cnt;
  int          q;
  logic [7:0]  ex;
  logic [7:0]  ey;

  initial begin
    // vld sof hsv rd gnt | we addr data page
    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 17'h00000, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 17'h00000, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'hBB, 1'b1, 1'b1, 1'b1, 17'h00000, 8'hAA, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 17'h00001, 8'hBB, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 17'h00000, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b0, 17'h00000, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 17'h00002, 8'hCC, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 17'h00002, 8'hCC, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 17'h00000, 8'h00, 1'b0};

    // Reset state.
    do_reset();
    @(negedge clk);
    check_reset_outputs("reset");
    next_cycle();

    // Vector table: basic push, pop, hold and page behaviour.
    for (int i = 0; i < 9; i++) begin
      vld     = vecs[i].vld;
      sof     = vecs[i].sof;
      hsv     = vecs[i].hsv;
      rd_page = vecs[i].rd_page;
      gnt     = vecs[i].gnt;
      @(negedge clk);
      check($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_addr", i), 32'(waddr), 32'(vecs[i].exp_addr));
        check($sformatf("vec%0d_data", i), 32'(wdata), 32'(vecs[i].exp_data));
      end
      check($sformatf("vec%0d_page", i), 32'(wr_page), 32'(vecs[i].exp_page));
      next_cycle();
    end

    // Full frame with gnt tied high: every pixel written in order, one done pulse.
    do_reset();
    rd_page = 1'b1;
    gnt     = 1'b1;
    wr_idx  = 0;
    fd_cnt  = 0;
    for (int p = 0; p < 61440 + 4; p++) begin
      if (p < 61440) begin
        q   = p >> 8;
        vld = 1'b1;
        sof = (p == 0);
        hsv = p[7:0] ^ q[7:0];
      end else begin
        vld = 1'b0;
        sof = 1'b0;
      end
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (we) begin
        q  = wr_idx >> 8;
        ex = wr_idx[7:0];
        ey = q[7:0];
        check("frame_addr", 32'(waddr), 32'({1'b0, ey, ex}));
        check("frame_data", 32'(wdata), 32'(ex ^ ey));
        wr_idx++;
      end
      next_cycle();
    end
    check("frame_writes", 32'(wr_idx), 32'd61440);
    check("frame_done_pulses", 32'(fd_cnt), 32'd1);
    check("frame_short", 32'(err_short), 32'd0);
    check("frame_ovf", 32'(err_ovf), 32'd0);

    // In DONE, pixels without sof are discarded.
    for (int k = 0; k < 4; k++) begin
      vld = (k < 3);
      sof = 1'b0;
      hsv = 8'h5A;
      @(negedge clk);
      check("done_discard_we", 32'(we), 32'd0);
      next_cycle();
    end
    vld = 1'b0;

    // Overflow: 10 pixels into 8 entries with no grant.
    do_reset();
    gnt = 1'b0;
    for (int i = 0; i < 10; i++) pixel(i == 0, 8'(i + 16));
    @(negedge clk);
    check("ovf_flag", 32'(err_ovf), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'(EXP_DROP));
    check("ovf_we", 32'(we), 32'd1);
    check("ovf_short", 32'(err_short), 32'd0);
    next_cycle();
    gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("ovf_drain_we", 32'(we), 32'd1);
      check("ovf_drain_addr", 32'(waddr), 32'(i));
      check("ovf_drain_data", 32'(wdata), 32'(i + 16));
      next_cycle();
    end
    @(negedge clk);
    check("ovf_drained_we", 32'(we), 32'd0);
    check("ovf_sticky", 32'(err_ovf), 32'd1);
    next_cycle();
    pixel(1'b0, 8'h55);
    @(negedge clk);
    check("ovf_next_addr", 32'(waddr), 32'd10);
    check("ovf_next_data", 32'(wdata), 32'h55);
    next_cycle();

    // Short frame: sof after 1000 pixels, page flips, queued entries keep their page.
    do_reset();
    rd_page = 1'b1;
    gnt     = 1'b1;
    for (int p = 0; p < 1000; p++) pixel(p == 0, p[7:0]);
    gnt = 1'b0;
    pixel(1'b0, 8'hE8);
    rd_page = 1'b0;
    pixel(1'b1, 8'h77);
    @(negedge clk);
    check("short_flag", 32'(err_short), 32'd1);
    check("short_page", 32'(wr_page), 32'd1);
    check("short_ovf", 32'(err_ovf), 32'd0);
    next_cycle();
    gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("short_drain_we", 32'(we), 32'd1);
      case (i)
        0: begin
          check("short_addr0", 32'(waddr), 32'({1'b0, 8'd3, 8'd231}));
          check("short_data0", 32'(wdata), 32'hE7);
        end
        1: begin
          check("short_addr1", 32'(waddr), 32'({1'b0, 8'd3, 8'd232}));
          check("short_data1", 32'(wdata), 32'hE8);
        end
        default: begin
          check("short_addr2", 32'(waddr), 32'({1'b1, 8'd0, 8'd0}));
          check("short_data2", 32'(wdata), 32'h77);
        end
      endcase
      next_cycle();
    end
    @(negedge clk);
    check("short_drained_we", 32'(we), 32'd0);
    next_cycle();

    // Full FIFO with a pop in the same cycle as a new pixel: no drop.
    do_reset();
    gnt = 1'b0;
    for (int i = 0; i < 8; i++) pixel(i == 0, 8'(i));
    gnt = 1'b1;
    pixel(1'b0, 8'd8);
    gnt = 1'b0;
    @(negedge clk);
    check("fullpop_ovf", 32'(err_ovf), 32'd0);
    check("fullpop_drop", 32'(drop_cnt), 32'd0);
    next_cycle();
    gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("fullpop_we", 32'(we), 32'd1);
      check("fullpop_addr", 32'(waddr), 32'(i + 1));
      check("fullpop_data", 32'(wdata), 32'(i + 1));
      next_cycle();
    end
    @(negedge clk);
    check("fullpop_empty", 32'(we), 32'd0);
    next_cycle();

    // Reset mid-frame with 5 entries queued and err_short set.
    do_reset();
    gnt = 1'b0;
    pixel(1'b1, 8'h01);
    pixel(1'b0, 8'h02);
    pixel(1'b0, 8'h03);
    pixel(1'b1, 8'h04);
    pixel(1'b0, 8'h05);
    @(negedge clk);
    check("midrst_pre_short", 32'(err_short), 32'd1);
    check("midrst_pre_we", 32'(we), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    next_cycle();
    rstn = 1'b1;
    gnt  = 1'b1;
    // IDLE after reset: pixels without sof must not produce requests.
    for (int k = 0; k < 4; k++) begin
      vld = (k < 3);
      sof = 1'b0;
      hsv = 8'h33;
      @(negedge clk);
      check("idle_discard_we", 32'(we), 32'd0);
      next_cycle();
    end
    pixel(1'b1, 8'h99);
    @(negedge clk);
    check("post_rst_we", 32'(we), 32'd1);
    check("post_rst_addr", 32'(waddr), 32'd0);
    check("post_rst_data", 32'(wdata), 32'h99);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
